// File: rtl/traffic_phase_controller.sv
`default_nettype none
// ============================================================================
// Module   : traffic_phase_controller
// Purpose  : N-channel traffic-light phase controller. Round-robin green
//            sequencing that skips approaches with no latched demand, rests
//            in green when nobody else is waiting, and drops into a flashing
//            yellow mode while 'flash' is held. All phase durations are
//            counted in ticks of a free-running prescaler.
// Optional : define TLC_PED_EN to add pedestrian buttons and walk lamps.
// Ports    : clk      - system clock, rising edge
//            reset    - synchronous, active-low reset
//            req      - per-channel vehicle demand (level)
//            flash    - flashing-yellow fault mode request (level)
//            ped_btn  - per-channel pedestrian button (TLC_PED_EN only)
//            walk     - per-channel walk lamp (TLC_PED_EN only)
//            lights   - channel i at [3i+2:3i] = {Red, Yellow, Green}
//            cur_ch   - channel currently owning green/yellow
// Revision : 1.0 - initial release
// ============================================================================
module traffic_phase_controller #(
    parameter int N_CH        = 2,
    parameter int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1,
    parameter int TICK_CYCLES = 50_000_000,
    parameter int GREEN_T     = 10,
    parameter int YELLOW_T    = 3,
    parameter int ALLRED_T    = 1,
    parameter int WALK_T      = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_CH-1:0]     req,
    input  logic                flash,
`ifdef TLC_PED_EN
    input  logic [N_CH-1:0]     ped_btn,
    output logic [N_CH-1:0]     walk,
`endif
    output logic [3*N_CH-1:0]   lights,
    output logic [CH_W-1:0]     cur_ch
);

    // Prescaler width; a one-cycle tick still needs a 1-bit counter.
    localparam int c_PW   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    // Timer only has to reach the longest duration minus one (green saturates).
    localparam int c_MAX1 = (GREEN_T > YELLOW_T) ? GREEN_T : YELLOW_T;
    localparam int c_MAX2 = (ALLRED_T > WALK_T) ? ALLRED_T : WALK_T;
    localparam int c_MAXD = (c_MAX1 > c_MAX2) ? c_MAX1 : c_MAX2;
    localparam int c_TW   = $clog2(c_MAXD + 1);

    localparam logic [1:0] c_ST_ALLRED = 2'd0;
    localparam logic [1:0] c_ST_GREEN  = 2'd1;
    localparam logic [1:0] c_ST_YELLOW = 2'd2;
    localparam logic [1:0] c_ST_FLASH  = 2'd3;

    localparam logic [2:0] c_RED = 3'b100;
    localparam logic [2:0] c_YEL = 3'b010;
    localparam logic [2:0] c_GRN = 3'b001;
    localparam logic [2:0] c_OFF = 3'b000;

    logic [1:0]        r_state, w_state_nx;
    logic [CH_W-1:0]   r_cur, w_cur_nx;
    logic [c_PW-1:0]   r_presc, w_presc_nx;
    logic [c_TW-1:0]   r_timer, w_timer_nx;
    logic              r_flash_on, w_flash_on_nx;
    logic [N_CH-1:0]   r_dem, w_dem_nx, w_dem_set;

    logic              w_tick;
    logic [N_CH-1:0]   w_cur_mask, w_sel_mask, w_green_mask;
    logic [CH_W-1:0]   w_sel, w_cur_inc;
    int                w_best;
    logic              w_other_dem;
    logic              w_enter_green;
    logic [3*N_CH-1:0] w_lights;

`ifdef TLC_PED_EN
    logic [N_CH-1:0]   r_pw, w_pw_nx, w_pw_set;
    logic              r_walk_act, w_walk_act_nx;
`endif

    assign w_tick    = (r_presc == c_PW'(TICK_CYCLES - 1));
    assign w_cur_inc = (r_cur == CH_W'(N_CH - 1)) ? '0 : r_cur + 1'b1;

    // ------------------------------------------------------------------
    // Next-channel selection: nearest channel with demand going round
    // from cur+1; the current channel itself is considered last.
    // ------------------------------------------------------------------
    always_comb begin
        w_sel  = w_cur_inc;
        w_best = N_CH;
        for (int i = 0; i < N_CH; i++) begin
            if (r_dem[i] && (((i - int'(r_cur) + N_CH - 1) % N_CH) < w_best)) begin
                w_best = (i - int'(r_cur) + N_CH - 1) % N_CH;
                w_sel  = CH_W'(i);
            end
        end
    end

    always_comb begin
        w_cur_mask = '0;
        w_sel_mask = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_cur_mask[i] = (r_cur == CH_W'(i));
            w_sel_mask[i] = (w_sel == CH_W'(i));
        end
    end

    assign w_green_mask = (r_state == c_ST_GREEN) ? w_cur_mask : '0;
    assign w_other_dem  = |(r_dem & ~w_cur_mask);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nx    = r_state;
        w_cur_nx      = r_cur;
        w_presc_nx    = w_tick ? '0 : r_presc + 1'b1;
        w_timer_nx    = r_timer;
        w_flash_on_nx = r_flash_on;

        if (flash) begin
            if (r_state != c_ST_FLASH) begin
                w_state_nx    = c_ST_FLASH;
                w_presc_nx    = '0;
                w_timer_nx    = '0;
                w_flash_on_nx = 1'b1;
            end else if (w_tick) begin
                w_flash_on_nx = ~r_flash_on;
            end
        end else if (r_state == c_ST_FLASH) begin
            w_state_nx = c_ST_ALLRED;
            w_presc_nx = '0;
            w_timer_nx = '0;
        end else begin
            case (r_state)
                c_ST_ALLRED: begin
                    if (w_tick) begin
                        if (r_timer == c_TW'(ALLRED_T - 1)) begin
                            w_state_nx = c_ST_GREEN;
                            w_cur_nx   = w_sel;
                            w_timer_nx = '0;
                        end else begin
                            w_timer_nx = r_timer + 1'b1;
                        end
                    end
                end
                c_ST_GREEN: begin
                    // Timer saturates at GREEN_T-1 while resting in green.
                    if (w_tick) begin
                        if (r_timer >= c_TW'(GREEN_T - 1)) begin
                            if (w_other_dem) begin
                                w_state_nx = c_ST_YELLOW;
                                w_timer_nx = '0;
                            end
                        end else begin
                            w_timer_nx = r_timer + 1'b1;
                        end
                    end
                end
                c_ST_YELLOW: begin
                    if (w_tick) begin
                        if (r_timer == c_TW'(YELLOW_T - 1)) begin
                            w_state_nx = c_ST_ALLRED;
                            w_timer_nx = '0;
                        end else begin
                            w_timer_nx = r_timer + 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nx = c_ST_ALLRED;
                    w_timer_nx = '0;
                end
            endcase
        end
    end

    assign w_enter_green = (w_state_nx == c_ST_GREEN) && (r_state != c_ST_GREEN);

    // Demand latches: set while the channel is not green, cleared on entry.
`ifdef TLC_PED_EN
    assign w_dem_set = r_dem | ((req | ped_btn) & ~w_green_mask);
    assign w_pw_set  = r_pw | (ped_btn & ~w_green_mask);
    assign w_pw_nx   = w_enter_green ? (w_pw_set & ~w_sel_mask) : w_pw_set;

    always_comb begin
        w_walk_act_nx = r_walk_act;
        if (w_enter_green) begin
            w_walk_act_nx = |(w_pw_set & w_sel_mask);
        end else if ((r_state != c_ST_GREEN) || (w_state_nx != c_ST_GREEN)) begin
            w_walk_act_nx = 1'b0;
        end else if (w_tick && (r_timer == c_TW'(WALK_T - 1))) begin
            w_walk_act_nx = 1'b0;
        end
    end
`else
    assign w_dem_set = r_dem | (req & ~w_green_mask);
`endif
    assign w_dem_nx = w_enter_green ? (w_dem_set & ~w_sel_mask) : w_dem_set;

    // ------------------------------------------------------------------
    // Lamp decode from the registered state; registered again below.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_lamp
        assign w_lights[3*gi +: 3] =
            (r_state == c_ST_FLASH)                  ? (r_flash_on ? c_YEL : c_OFF) :
            ((r_state == c_ST_GREEN)  && w_cur_mask[gi]) ? c_GRN :
            ((r_state == c_ST_YELLOW) && w_cur_mask[gi]) ? c_YEL : c_RED;
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= c_ST_ALLRED;
            r_cur      <= CH_W'(N_CH - 1);
            r_presc    <= '0;
            r_timer    <= '0;
            r_flash_on <= 1'b0;
            r_dem      <= '0;
            lights     <= {N_CH{c_RED}};
            cur_ch     <= CH_W'(N_CH - 1);
`ifdef TLC_PED_EN
            r_pw       <= '0;
            r_walk_act <= 1'b0;
            walk       <= '0;
`endif
        end else begin
            r_state    <= w_state_nx;
            r_cur      <= w_cur_nx;
            r_presc    <= w_presc_nx;
            r_timer    <= w_timer_nx;
            r_flash_on <= w_flash_on_nx;
            r_dem      <= w_dem_nx;
            lights     <= w_lights;
            cur_ch     <= r_cur;
`ifdef TLC_PED_EN
            r_pw       <= w_pw_nx;
            r_walk_act <= w_walk_act_nx;
            walk       <= r_walk_act ? w_cur_mask : '0;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_phase_controller
// Purpose  : Scoreboard bench for traffic_phase_controller (N_CH=3,
//            TICK_CYCLES=4, GREEN_T=3, YELLOW_T=2, ALLRED_T=1, WALK_T=2).
//            Stimulus pushes cycle-stamped expectations; a monitor pops and
//            compares them on the falling edge. Cycle k = state after the
//            k-th rising edge following the reset edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_phase_controller;

    localparam logic [8:0] c_RED = 9'b100_100_100;
    localparam logic [8:0] c_G0  = 9'b100_100_001;
    localparam logic [8:0] c_Y0  = 9'b100_100_010;
    localparam logic [8:0] c_G1  = 9'b100_001_100;
    localparam logic [8:0] c_Y1  = 9'b100_010_100;
    localparam logic [8:0] c_G2  = 9'b001_100_100;
    localparam logic [8:0] c_Y2  = 9'b010_100_100;
    localparam logic [8:0] c_FY  = 9'b010_010_010;
    localparam logic [8:0] c_FO  = 9'b000_000_000;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       flash = 1'b0;
    logic [2:0] req   = 3'b000;
    logic [8:0] lights;
    logic [1:0] cur_ch;
`ifdef TLC_PED_EN
    logic [2:0] ped_btn = 3'b000;
    logic [2:0] walk;
`endif

    traffic_phase_controller #(
        .N_CH(3), .CH_W(2), .TICK_CYCLES(4), .GREEN_T(3),
        .YELLOW_T(2), .ALLRED_T(1), .WALK_T(2)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .flash  (flash),
`ifdef TLC_PED_EN
        .ped_btn(ped_btn),
        .walk   (walk),
`endif
        .lights (lights),
        .cur_ch (cur_ch)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [8:0] l;
        logic [1:0] c;
        logic       wchk;
        logic [2:0] w;
        string      nm;
    } exp_t;

    exp_t sb[$];
    int   b      = 0;
    int   n_cmp  = 0;
    int   n_err  = 0;

    task automatic push(input int k, input logic [8:0] l, input logic [1:0] c, input string nm);
        exp_t e;
        e.cyc = b + k; e.l = l; e.c = c; e.wchk = 1'b0; e.w = 3'b000; e.nm = nm;
        sb.push_back(e);
    endtask

    task automatic pushw(input int k, input logic [8:0] l, input logic [1:0] c,
                         input logic [2:0] w, input string nm);
        exp_t e;
        e.cyc = b + k; e.l = l; e.c = c; e.wchk = 1'b1; e.w = w; e.nm = nm;
        sb.push_back(e);
    endtask

    // Monitor: compares every expectation whose cycle has arrived.
    always @(negedge clk) begin
        exp_t e;
        logic [2:0] wv;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_cmp++;
            wv = 3'b000;
`ifdef TLC_PED_EN
            wv = walk;
`endif
            if (e.cyc < cyc) begin
                n_err++;
                $display("FAIL %s: expectation for cycle %0d missed (now %0d)", e.nm, e.cyc, cyc);
            end else if (lights !== e.l || cur_ch !== e.c || (e.wchk && wv !== e.w)) begin
                n_err++;
                $display("FAIL %s: cyc %0d lights=%b cur=%0d walk=%b, expected lights=%b cur=%0d walk=%b",
                         e.nm, cyc - b, lights, cur_ch, wv, e.l, e.c, e.w);
            end
        end
    end

    // Waits until the negedge of relative cycle k, then returns for driving.
    task automatic at_cyc(input int k);
        do @(negedge clk); while (cyc < b + k);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; flash = 1'b0; req = 3'b000;
`ifdef TLC_PED_EN
        ped_btn = 3'b000;
`endif
        @(negedge clk);
        b     = cyc;
        reset = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d expectations never reached", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        // Rest in ch0 green with no demand.
        do_reset();
        push(1, c_RED, 2, "s1_red1");   push(4, c_RED, 2, "s1_red4");
        push(5, c_G0, 0, "s1_green5");  push(16, c_G0, 0, "s1_g16");
        push(17, c_G0, 0, "s1_g17");    push(40, c_G0, 0, "s1_rest40");
        drain();

        // One-cycle req[2]: ch1 skipped, ch2 served.
        do_reset();
        push(5, c_G0, 0, "s2_g5");      push(16, c_G0, 0, "s2_g16");
        push(17, c_Y0, 0, "s2_y17");    push(24, c_Y0, 0, "s2_y24");
        push(25, c_RED, 0, "s2_r25");   push(28, c_RED, 0, "s2_r28");
        push(29, c_G2, 2, "s2_g2_29");  push(45, c_G2, 2, "s2_rest45");
        at_cyc(6); req = 3'b100;
        at_cyc(7); req = 3'b000;
        drain();

        // All channels demanding: 0,1,2,0.
        do_reset();
        req = 3'b111;
        push(5, c_G0, 0, "s3_g0");      push(16, c_G0, 0, "s3_g0_end");
        push(17, c_Y0, 0, "s3_y0");     push(25, c_RED, 0, "s3_r0");
        push(29, c_G1, 1, "s3_g1");     push(40, c_G1, 1, "s3_g1_end");
        push(41, c_Y1, 1, "s3_y1");     push(49, c_RED, 1, "s3_r1");
        push(53, c_G2, 2, "s3_g2");     push(65, c_Y2, 2, "s3_y2");
        push(73, c_RED, 2, "s3_r2");    push(77, c_G0, 0, "s3_g0_again");
        drain();
        req = 3'b000;

        // Flash mid-green with a demand latched during flash.
        do_reset();
        push(9, c_G0, 0, "s4_g9");      push(10, c_FY, 0, "s4_fy10");
        push(13, c_FY, 0, "s4_fy13");   push(14, c_FO, 0, "s4_fo14");
        push(17, c_FO, 0, "s4_fo17");   push(18, c_FY, 0, "s4_fy18");
        push(22, c_FO, 0, "s4_fo22");   push(26, c_FY, 0, "s4_fy26");
        push(29, c_FY, 0, "s4_fy29");   push(30, c_RED, 0, "s4_r30");
        push(33, c_RED, 0, "s4_r33");   push(34, c_G1, 1, "s4_g1_34");
        at_cyc(8);  flash = 1'b1;
        at_cyc(15); req = 3'b010;
        at_cyc(16); req = 3'b000;
        at_cyc(28); flash = 1'b0;
        drain();

        // Reset pulse during yellow; pending ch2 demand is discarded.
        do_reset();
        push(17, c_Y0, 0, "s5_y17");    push(19, c_Y0, 0, "s5_y19");
        push(20, c_RED, 2, "s5_rst20");
        at_cyc(6);  req = 3'b100;
        at_cyc(7);  req = 3'b000;
        at_cyc(19); reset = 1'b0;
        at_cyc(20); reset = 1'b1; b = cyc;
        push(1, c_RED, 2, "s5_red1");   push(4, c_RED, 2, "s5_red4");
        push(5, c_G0, 0, "s5_g5");      push(30, c_G0, 0, "s5_rest30");
        drain();

`ifdef TLC_PED_EN
        // Pedestrian walk on ch1, none on its next green.
        do_reset();
        pushw(28, c_RED, 0, 3'b000, "s6_r28");
        pushw(29, c_G1, 1, 3'b010, "s6_walk_on");
        pushw(36, c_G1, 1, 3'b010, "s6_walk_last");
        pushw(37, c_G1, 1, 3'b000, "s6_walk_off");
        pushw(41, c_Y1, 1, 3'b000, "s6_y1");
        pushw(53, c_G0, 0, 3'b000, "s6_g0");
        pushw(77, c_G1, 1, 3'b000, "s6_g1_nowalk");
        pushw(80, c_G1, 1, 3'b000, "s6_g1_nowalk80");
        at_cyc(6);  ped_btn = 3'b010;
        at_cyc(7);  ped_btn = 3'b000;
        at_cyc(37); req = 3'b001;
        at_cyc(38); req = 3'b000;
        at_cyc(53); req = 3'b010;
        at_cyc(54); req = 3'b000;
        drain();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
